// File: rtl/sub_pkg.sv
// Shared state encodings for the bit-serial subtractor controller.
package sub_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/full_subtractor.sv
// 1-bit full subtractor cell: diff = a - b - cin, borrow out when a < b + cin.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic diff,
    output logic borrow
);
    assign diff   = a ^ b ^ cin;
    assign borrow = (~a & b) | (~(a ^ b) & cin);
endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial A - B - BIN, LSB first, through one shared full_subtractor.
// The result is published on the RUN->DONE edge and is held until the next one.
module serial_sub_ctrl
    import sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic             fs_diff, fs_borrow;

    full_subtractor u_fs (
        .a      (a_sr[0]),
        .b      (b_sr[0]),
        .cin    (brw),
        .diff   (fs_diff),
        .borrow (fs_borrow)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            brw    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        brw   <= bin;
                        cnt   <= '0;
                        state <= ST_RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // diff bits enter at the MSB so the LSB-first stream lands in place
                    res_sr <= {fs_diff, res_sr[WIDTH-1:1]};
                    brw    <= fs_borrow;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        diff   <= {fs_diff, res_sr[WIDTH-1:1]};
                        borrow <= fs_borrow;
                        state  <= ST_DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
Bit-serial multi-bit subtractor controller. Computes A - B - BIN one bit per clock, LSB first, through a single instance of the team's 1-bit full_subtractor cell. Accepts operands on a start/busy/done handshake and holds the result until the next operation. Used wherever area matters more than latency and one subtract cell is shared across all bit positions.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 2..32)

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous, active-high reset
start  in  1  request pulse; sampled only in IDLE or DONE
a  in  WIDTH  minuend; sampled on the start-accept edge
b  in  WIDTH  subtrahend; sampled on the start-accept edge
bin  in  1  initial borrow-in; sampled on the start-accept edge
busy  out  1  high while an operation is in progress (RUN)
done  out  1  one-cycle pulse when the result becomes valid
diff  out  WIDTH  result A - B - BIN modulo 2^WIDTH
borrow  out  1  final borrow-out (1 = A < B + BIN, unsigned)

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately, including mid-operation): state=IDLE, busy=0, done=0, diff=0, borrow=0, internal shift registers, counter and borrow flop = 0. An in-flight operation is discarded. No done is generated.
- FSM states: IDLE, RUN, DONE. busy = (state==RUN). done = (state==DONE).
- IDLE: start=1 at edge E0 latches a->a_sr, b->b_sr, bin->brw, cnt=0, state->RUN. start=0 holds IDLE.
- RUN: each edge feeds a_sr[0], b_sr[0], brw to full_subtractor. Capture diff bit into the MSB of a result shift register (shift right). Capture borrow into brw. Shift a_sr and b_sr right. Increment cnt.
- RUN exit: on the edge where cnt==WIDTH-1, i.e. edge E(WIDTH), load diff from the completed result register, load borrow from the final borrow, and go to DONE. Latency is WIDTH clocks from the start-accept edge to done high.
- DONE: lasts exactly one cycle. start=1 in DONE is accepted as in IDLE (back-to-back ops; busy rises the next cycle). Otherwise go to IDLE.
- start in RUN is ignored. Operands are not re-sampled and no error is flagged.
- diff/borrow change only on the RUN->DONE edge. They hold the previous result during RUN and indefinitely in IDLE.
- a, b, bin may change freely after the accept edge without affecting the result.
- Counter width: $clog2(WIDTH). No wrap is ever reached because the exit is at WIDTH-1.
- Arithmetic: unsigned, modulo 2^WIDTH. The result is bit-exact to {borrow,diff} = {1'b0,a} - {1'b0,b} - bin, taken modulo 2^(WIDTH+1) with borrow as the sign bit.

Decomposition:
- Shared constants include file sub_pkg: FSM state encodings (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2).
- One sub-module: the existing full_subtractor (ports a, b, cin, diff, borrow), instantiated once as the bit-slice datapath.
- serial_sub_ctrl contains: the FSM, the bit counter, operand and result shift registers, and the borrow flop.

Test Plan:
1. WIDTH=8, a=0x5A, b=0x3C, bin=0, start pulse -> busy for 8 cycles, done pulse on the 8th edge after accept, diff=0x1E, borrow=0.
2. a=0x00, b=0x01, bin=0 -> diff=0xFF, borrow=1. Then a=0x80, b=0x7F, bin=1 -> diff=0x00, borrow=0.
3. a=0xFF, b=0xFF, bin=1 -> diff=0xFF, borrow=1. All 8 borrow stages propagate.
4. start held high continuously with operands changing every cycle -> ops accepted only in IDLE/DONE, one result per 9 cycles. Each result matches the operands present on its accept edge; start during RUN has no effect.
5. Assert rst asynchronously (mid-cycle) at RUN cycle 4 -> busy, done, diff, borrow go to 0 immediately without a clock edge. After release, a fresh op 0x10-0x01 -> diff=0x0F, borrow=0, normal latency.
6. Randomised self-check: 500 random a/b/bin ops at WIDTH=8 and WIDTH=13 vs the reference model {1'b0,a}-{1'b0,b}-bin -> zero mismatches, done exactly once per accepted start.
